// File: rtl/alu_result_stage.sv
// Two-entry result FIFO behind the ALU: derives {N,Z,C,V} on push, keeps last-popped flags.
// Optional sticky overflow indicator enabled by defining ALU_STICKY_OVF_EN.
module alu_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] arith_out,
    input  logic             c_in,
    input  logic             v_in,
    input  logic [3:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [3:0]       status,
    output logic [1:0]       count,
    input  logic             ovf_clr,
    output logic             sticky_v
);

    logic [WIDTH-1:0] data0, data1;
    logic [3:0]       flg0, flg1;
    logic [1:0]       cnt;
    logic [3:0]       status_q;
    logic             push, pop;
    logic             new_c, new_v;
    logic [3:0]       new_flags;
    logic             unused_op;

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Set-less-than results carry no meaningful carry/overflow, so they are masked.
    assign new_c     = c_in & aluop[0] & ~aluop[3];
    assign new_v     = v_in & aluop[0] & ~aluop[3];
    assign new_flags = {arith_out[WIDTH-1], (arith_out == '0), new_c, new_v};
    assign unused_op = ^aluop[2:1];

    assign count  = cnt;
    assign status = status_q;
    assign result = out_valid ? data0 : '0;
    assign flags  = out_valid ? flg0 : 4'd0;

    // Entry 0 is always the head; entry 1 shifts down on a pop from a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data0    <= '0;
            data1    <= '0;
            flg0     <= 4'd0;
            flg1     <= 4'd0;
            cnt      <= 2'd0;
            status_q <= 4'd0;
        end else begin
            if (pop) begin
                status_q <= flg0;
            end
            case (cnt)
                2'd0: begin
                    if (push) begin
                        data0 <= arith_out;
                        flg0  <= new_flags;
                        cnt   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        data0 <= arith_out;
                        flg0  <= new_flags;
                    end else if (push) begin
                        data1 <= arith_out;
                        flg1  <= new_flags;
                        cnt   <= 2'd2;
                    end else if (pop) begin
                        cnt   <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        data0 <= data1;
                        flg0  <= flg1;
                        cnt   <= 2'd1;
                    end
                end
                default: cnt <= 2'd0;
            endcase
        end
    end

`ifdef ALU_STICKY_OVF_EN
    logic sticky_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (push && new_v) begin
            sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign sticky_v = sticky_q;
`else
    logic unused_clr;

    assign sticky_v   = 1'b0;
    assign unused_clr = ovf_clr;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios then random traffic vs a queue model.
module tb_alu_result_stage;

    localparam int W = 32;
`ifdef ALU_STICKY_OVF_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] arith_out;
    logic         c_in;
    logic         v_in;
    logic [3:0]   aluop;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic [3:0]   status;
    logic [1:0]   count;
    logic         ovf_clr;
    logic         sticky_v;

    alu_result_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .arith_out(arith_out), .c_in(c_in), .v_in(v_in), .aluop(aluop),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags(flags), .status(status), .count(count), .ovf_clr(ovf_clr),
        .sticky_v(sticky_v)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic [3:0]   f;
    } ent_t;

    ent_t     q[$];
    logic [3:0] m_status;
    logic       m_sticky;
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_flags(input logic [W-1:0] d, input logic c,
                                             input logic v, input logic [3:0] op);
        logic cm, vm;
        cm = (op[3] == 1'b1) ? 1'b0 : (c & op[0]);
        vm = (op[3] == 1'b1) ? 1'b0 : (v & op[0]);
        return {d[W-1], d == 0, cm, vm};
    endfunction

    task automatic model_step();
        bit   do_push, do_pop;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_status = 4'd0;
            m_sticky = 1'b0;
        end else begin
            do_push = in_valid && (q.size() < 2);
            do_pop  = out_ready && (q.size() > 0);
            e.d = arith_out;
            e.f = ref_flags(arith_out, c_in, v_in, aluop);
            if (do_pop) begin
                m_status = q[0].f;
                void'(q.pop_front());
            end
            if (do_push) q.push_back(e);
            if (STICKY_EN) begin
                if (do_push && e.f[0]) m_sticky = 1'b1;
                else if (ovf_clr) m_sticky = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string pfx);
        check({pfx, ".count"}, 64'(count), 64'(q.size()));
        check({pfx, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        check({pfx, ".in_ready"}, 64'(in_ready), 64'(q.size() != 2));
        check({pfx, ".result"}, 64'(result), (q.size() != 0) ? 64'(q[0].d) : 64'd0);
        check({pfx, ".flags"}, 64'(flags), (q.size() != 0) ? 64'(q[0].f) : 64'd0);
        check({pfx, ".status"}, 64'(status), 64'(m_status));
        check({pfx, ".sticky_v"}, 64'(sticky_v), 64'(m_sticky));
    endtask

    task automatic cyc(input logic rst, input logic iv, input logic [W-1:0] d,
                       input logic c, input logic v, input logic [3:0] op,
                       input logic ordy, input logic clr, input string pfx);
        rst_n = rst; in_valid = iv; arith_out = d; c_in = c; v_in = v;
        aluop = op; out_ready = ordy; ovf_clr = clr;
        @(posedge clk);
        model_step();
        #1;
        check_all(pfx);
    endtask

    initial begin
        m_status = 4'd0;
        m_sticky = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; arith_out = '0; c_in = 1'b0; v_in = 1'b0;
        aluop = 4'd0; out_ready = 1'b0; ovf_clr = 1'b0;

        cyc(0, 0, 0, 0, 0, 4'h0, 0, 0, "rst");
        cyc(0, 1, 32'h5, 1, 1, 4'h1, 1, 0, "rst2");
        check("rst.count_const", 64'(count), 64'd0);
        check("rst.in_ready_const", 64'(in_ready), 64'd1);

        // Basic overflow push and status update.
        cyc(1, 1, 32'h7FFF_FFFF, 0, 1, 4'b0011, 1, 0, "r31a");
        check("r31.result", 64'(result), 64'h7FFF_FFFF);
        check("r31.flags", 64'(flags), 64'b0001);
        cyc(1, 0, 0, 0, 0, 4'h0, 1, 0, "r31b");
        check("r31.status", 64'(status), 64'b0001);

        // Set-less-than masks C/V.
        cyc(1, 1, 32'h0, 1, 1, 4'b1011, 0, 0, "r32a");
        check("r32.flags", 64'(flags), 64'b0100);
        cyc(1, 0, 0, 0, 0, 4'h0, 1, 0, "r32b");

        // Full FIFO refuses third push; order preserved.
        cyc(1, 1, 32'h1, 0, 0, 4'h0, 0, 0, "r33a");
        cyc(1, 1, 32'h2, 0, 0, 4'h0, 0, 0, "r33b");
        cyc(1, 1, 32'h3, 0, 0, 4'h0, 0, 0, "r33c");
        check("r33.count_full", 64'(count), 64'd2);
        check("r33.in_ready", 64'(in_ready), 64'd0);
        check("r33.head1", 64'(result), 64'h1);
        cyc(1, 0, 0, 0, 0, 4'h0, 1, 0, "r33d");
        check("r33.head2", 64'(result), 64'h2);
        cyc(1, 0, 0, 0, 0, 4'h0, 1, 0, "r33e");
        check("r33.empty", 64'(count), 64'd0);

        // Simultaneous push/pop with one entry.
        cyc(1, 1, 32'hA, 0, 0, 4'h0, 0, 0, "r34a");
        cyc(1, 1, 32'hB, 0, 0, 4'h0, 1, 0, "r34b");
        check("r34.count", 64'(count), 64'd1);
        check("r34.result", 64'(result), 64'hB);

        // Reset while full, with push/pop requested.
        cyc(1, 1, 32'hC, 0, 1, 4'h1, 0, 0, "r35a");
        check("r35.full", 64'(count), 64'd2);
        cyc(0, 1, 32'hD, 0, 1, 4'h1, 1, 0, "r35b");
        check("r35.count", 64'(count), 64'd0);
        check("r35.out_valid", 64'(out_valid), 64'd0);
        check("r35.status", 64'(status), 64'd0);
        check("r35.sticky", 64'(sticky_v), 64'd0);

        // Sticky set beats clear; clear alone drops it.
        cyc(1, 1, 32'h10, 0, 1, 4'h1, 0, 1, "r36a");
        check("r36.set", 64'(sticky_v), 64'(STICKY_EN));
        cyc(1, 0, 0, 0, 0, 4'h0, 1, 1, "r36b");
        check("r36.clr", 64'(sticky_v), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] d;
            case ($urandom_range(0, 3))
                0: d = '0;
                1: d = 32'h8000_0000 | W'($urandom);
                default: d = W'($urandom);
            endcase
            cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 2) != 0), d,
                1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter WIDTH, default 32, data width of result path; SHALL be fixed at elaboration.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream arithmetic result valid.
REQ-005 in_ready  output  1  stage can accept; SHALL depend only on registered state.
REQ-006 arith_out  input  WIDTH  result from arithmetic unit.
REQ-007 c_in  input  1  carry flag from arithmetic unit.
REQ-008 v_in  input  1  overflow flag from arithmetic unit.
REQ-009 aluop  input  4  opcode accompanying the result.
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  downstream accepts head entry.
REQ-012 result  output  WIDTH  head entry data.
REQ-013 flags  output  4  head entry {N,Z,C,V}.
REQ-014 status  output  4  {N,Z,C,V} of last entry popped.
REQ-015 count  output  2  occupancy 0..2.
REQ-016 ovf_clr  input  1  clears sticky overflow.
REQ-017 sticky_v  output  1  sticky overflow indicator.

Function
REQ-018 Stage SHALL be a 2-entry FIFO; push when in_valid&in_ready, pop when out_valid&out_ready.
REQ-019 in_ready SHALL equal (count!=2); out_valid SHALL equal (count!=0).
REQ-020 Push SHALL capture N=arith_out[WIDTH-1], Z=(arith_out==0), C=c_in&aluop[0], V=v_in&aluop[0]; when aluop[3]=1 (set-less-than) C and V SHALL be stored as 0.
REQ-021 Latency: entry pushed into empty FIFO SHALL appear on result/flags with out_valid=1 the next cycle; no combinational in-to-out path.
REQ-022 Simultaneous push and pop with count=1 SHALL leave count=1 and present the new entry next cycle; ordering strictly FIFO.
REQ-023 With count=2 push SHALL be impossible (in_ready=0) even if out_ready=1 that cycle.
REQ-024 in_valid with in_ready=0 SHALL not alter state; out_ready with count=0 SHALL be ignored.
REQ-025 On each pop, status SHALL load the popped entry's flags the next cycle; otherwise hold.
REQ-026 result/flags SHALL be 0 when count=0.

Reset
REQ-027 rst_n=0 at a clock edge SHALL set count=0, out_valid=0, in_ready=1, result=0, flags=0, status=0, sticky_v=0.
REQ-028 Reset mid-operation SHALL discard all stored entries; a push or pop coincident with reset SHALL have no effect.

Configuration
REQ-029 Macro ALU_STICKY_OVF_EN defined: sticky_v SHALL set on any push with stored V=1 and clear on ovf_clr=1; set wins over simultaneous clear.
REQ-030 Macro undefined: sticky_v SHALL be constant 0 and ovf_clr SHALL be ignored; all other behaviour identical.

Verification
REQ-031 Push 0x7FFFFFFF, c_in=0, v_in=1, aluop=0011, out_ready=1 -> next cycle result=0x7FFFFFFF, flags=0001; following cycle status=0001.
REQ-032 Push 0x00000000 with aluop=1011, c_in=1, v_in=1 -> flags=0100 (Z only, C/V masked).
REQ-033 out_ready=0, push 0x1, 0x2, attempt 0x3 -> count=2, in_ready=0, 0x3 not stored; then out_ready=1 -> pops 0x1 then 0x2 in order.
REQ-034 count=1 (0xA), same cycle push 0xB and pop -> count stays 1, result=0xB next cycle.
REQ-035 count=2, assert rst_n=0 one cycle with in_valid=1 -> count=0, out_valid=0, status=0, sticky_v=0.
REQ-036 With ALU_STICKY_OVF_EN: push V=1 while ovf_clr=1 -> sticky_v=1; next cycle ovf_clr=1 alone -> sticky_v=0; without macro sticky_v stays 0 throughout.
